// File: rtl/pmem_arbiter_if.sv
// pmem_arbiter_if: cache-side request/response and burst memory-port signals of the arbiter
interface pmem_arbiter_if #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
);
  logic              inst_read;
  logic [31:0]       inst_addr;
  logic [LINE_W-1:0] inst_rdata;
  logic              inst_resp;
  logic              data_read;
  logic              data_write;
  logic [31:0]       data_addr;
  logic [LINE_W-1:0] data_wdata;
  logic [LINE_W-1:0] data_rdata;
  logic              data_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [31:0]       pmem_address;
  logic [BEAT_W-1:0] pmem_wdata;
  logic [BEAT_W-1:0] pmem_rdata;
  logic              pmem_resp;
  modport slave (
    input  inst_read, inst_addr, data_read, data_write, data_addr, data_wdata, pmem_rdata, pmem_resp,
    output inst_rdata, inst_resp, data_rdata, data_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );
  modport master (
    output inst_read, inst_addr, data_read, data_write, data_addr, data_wdata, pmem_rdata, pmem_resp,
    input  inst_rdata, inst_resp, data_rdata, data_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares the burst memory port between icache and dcache; define PMEM_ARB_RR_EN for round-robin grant
module pmem_arbiter #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input logic           clk,
  input logic           rst_n,
  pmem_arbiter_if.slave bus
);
  localparam int NB = LINE_W / BEAT_W;
  localparam int KW = $clog2(NB);
  localparam logic [KW-1:0] K_LAST = KW'(NB - 1);
  localparam logic [31:0] OFS_MASK = 32'(LINE_W / 8 - 1);
  localparam logic [2:0] IDLE = 3'd0, I_RD = 3'd1, D_RD = 3'd2, D_WR = 3'd3, DONE = 3'd4;
  logic [2:0]        r_state;
  logic [KW-1:0]     r_k;
  logic [LINE_W-1:0] r_line;
  logic [LINE_W-1:0] r_wline;
  logic [31:0]       r_addr;
  logic              r_rd;
  logic              r_wr;
  logic              r_iresp;
  logic              r_dresp;
  logic              w_dreq;
  logic              w_req;
  logic              w_gnt_d;
  logic              w_last;
  assign w_dreq = bus.data_read | bus.data_write;
  assign w_req  = w_dreq | bus.inst_read;
  assign w_last = bus.pmem_resp && r_k == K_LAST;
`ifdef PMEM_ARB_RR_EN
  logic r_last_d;
  // on contention the requester not served last time wins
  assign w_gnt_d = w_dreq & (~bus.inst_read | ~r_last_d);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_last_d <= 1'b0;
    else if (r_state == IDLE && w_req) r_last_d <= w_gnt_d;
`else
  assign w_gnt_d = w_dreq;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_line  <= '0;
      r_wline <= '0;
      r_addr  <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_iresp <= 1'b0;
      r_dresp <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_req) begin
          r_addr <= (w_gnt_d ? bus.data_addr : bus.inst_addr) & ~OFS_MASK;
          r_k    <= '0;
          r_rd   <= ~(w_gnt_d & bus.data_write);
          r_wr   <= w_gnt_d & bus.data_write;
          if (w_gnt_d & bus.data_write) r_wline <= bus.data_wdata;
          r_state <= !w_gnt_d ? I_RD : bus.data_write ? D_WR : D_RD;
        end
        I_RD, D_RD: if (bus.pmem_resp) begin
          r_line[int'(r_k) * BEAT_W +: BEAT_W] <= bus.pmem_rdata;
          r_k <= r_k + 1'b1;
          if (w_last) begin
            r_rd    <= 1'b0;
            r_iresp <= r_state == I_RD;
            r_dresp <= r_state == D_RD;
            r_state <= DONE;
          end
        end
        D_WR: if (bus.pmem_resp) begin
          r_k <= r_k + 1'b1;
          if (w_last) begin
            r_wr    <= 1'b0;
            r_dresp <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_iresp <= 1'b0;
          r_dresp <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.pmem_read    = r_rd;
  assign bus.pmem_write   = r_wr;
  assign bus.pmem_address = r_addr;
  assign bus.pmem_wdata   = r_state == D_WR ? r_wline[int'(r_k) * BEAT_W +: BEAT_W] : '0;
  assign bus.inst_resp    = r_iresp;
  assign bus.data_resp    = r_dresp;
  assign bus.inst_rdata   = r_line;
  assign bus.data_rdata   = r_line;
endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter: directed table and corner-sequence checks of the pmem arbiter
module tb_pmem_arbiter;
  typedef struct {
    logic        ir, dr, dw;
    logic [31:0] a;
    int          gap;
    logic [7:0]  x;
    logic [31:0] exp_addr;
    logic        exp_d, exp_w;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [63:0] rb[4];
  logic [63:0] wb[4];
  logic [255:0] exp_line = '0;
  vec_t vt[5];
  always #5 clk = ~clk;
  pmem_arbiter_if bus();
  pmem_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [255:0] line_of(input logic [7:0] x);
    return {rb[3], rb[2], rb[1], rb[0]} ^ {32{x}};
  endfunction
  task automatic beats(input int n, input int gap, input logic [7:0] x, input logic erd, input logic ewr, input string tag);
    for (int j = 0; j < n; j++) begin
      for (int g = 0; g < gap; g++) begin
        bus.pmem_resp = 1'b0;
        chk({tag, "/strobe_gap"}, {bus.pmem_read, bus.pmem_write}, {erd, ewr});
        chk({tag, "/wdata_gap"}, bus.pmem_wdata, ewr ? wb[j] : 64'h0);
        @(negedge clk);
      end
      bus.pmem_resp  = 1'b1;
      bus.pmem_rdata = rb[j] ^ {8{x}};
      chk({tag, "/strobe"}, {bus.pmem_read, bus.pmem_write}, {erd, ewr});
      chk({tag, "/wdata"}, bus.pmem_wdata, ewr ? wb[j] : 64'h0);
      @(negedge clk);
    end
    bus.pmem_resp = 1'b0;
  endtask
  task automatic finish_txn(input logic exp_d, input logic is_rd, input logic [7:0] x, input string tag);
    chk({tag, "/resp"}, {bus.inst_resp, bus.data_resp}, {~exp_d, exp_d});
    chk({tag, "/strobe_done"}, {bus.pmem_read, bus.pmem_write}, 2'b00);
    @(negedge clk);
    chk({tag, "/resp_pulse"}, {bus.inst_resp, bus.data_resp}, 2'b00);
    if (is_rd) exp_line = line_of(x);
    chk({tag, "/inst_rdata"}, bus.inst_rdata, exp_line);
    chk({tag, "/data_rdata"}, bus.data_rdata, exp_line);
  endtask
  task automatic run(input vec_t v, input string tag);
    bus.inst_read  = v.ir;
    bus.data_read  = v.dr;
    bus.data_write = v.dw;
    bus.inst_addr  = v.ir ? v.a : 32'hDEAD_BEEF;
    bus.data_addr  = v.ir ? 32'hDEAD_BEEF : v.a;
    @(negedge clk);
    bus.inst_read  = 1'b0;
    bus.data_read  = 1'b0;
    bus.data_write = 1'b0;
    chk({tag, "/addr"}, bus.pmem_address, v.exp_addr);
    beats(4, v.gap, v.x, ~v.exp_w, v.exp_w, tag);
    finish_txn(v.exp_d, ~v.exp_w, v.x, tag);
  endtask
  task automatic contend(input logic dfirst, input string tag);
    bus.inst_read = 1'b1;
    bus.inst_addr = 32'h0000_0104;
    bus.data_read = 1'b1;
    bus.data_addr = 32'h0000_0208;
    @(negedge clk);
    chk({tag, "/addr1"}, bus.pmem_address, dfirst ? 32'h0000_0200 : 32'h0000_0100);
    beats(4, 0, 8'h00, 1'b1, 1'b0, {tag, "/b1"});
    chk({tag, "/resp1"}, {bus.inst_resp, bus.data_resp}, {~dfirst, dfirst});
    if (dfirst) bus.data_read = 1'b0;
    else bus.inst_read = 1'b0;
    @(negedge clk);
    chk({tag, "/idle_strobe"}, {bus.pmem_read, bus.pmem_write}, 2'b00);
    @(negedge clk);
    chk({tag, "/addr2"}, bus.pmem_address, dfirst ? 32'h0000_0100 : 32'h0000_0200);
    bus.inst_read = 1'b0;
    bus.data_read = 1'b0;
    beats(4, 0, 8'h77, 1'b1, 1'b0, {tag, "/b2"});
    finish_txn(~dfirst, 1'b1, 8'h77, {tag, "/t2"});
  endtask
  initial begin
    rb[0] = {16{4'h1}}; rb[1] = {16{4'h2}}; rb[2] = {16{4'h3}}; rb[3] = {16{4'h4}};
    wb[0] = {8{8'hD0}}; wb[1] = {8{8'hD1}}; wb[2] = {8{8'hD2}}; wb[3] = {8{8'hD3}};
    vt[0] = '{ir: 1, dr: 0, dw: 0, a: 32'h0000_0064, gap: 0, x: 8'h00, exp_addr: 32'h0000_0060, exp_d: 0, exp_w: 0};
    vt[1] = '{ir: 0, dr: 0, dw: 1, a: 32'h8000_0020, gap: 2, x: 8'h00, exp_addr: 32'h8000_0020, exp_d: 1, exp_w: 1};
    vt[2] = '{ir: 0, dr: 1, dw: 0, a: 32'h1234_567F, gap: 1, x: 8'hA5, exp_addr: 32'h1234_5660, exp_d: 1, exp_w: 0};
    vt[3] = '{ir: 0, dr: 1, dw: 1, a: 32'h0000_003F, gap: 0, x: 8'h00, exp_addr: 32'h0000_0020, exp_d: 1, exp_w: 1};
    vt[4] = '{ir: 1, dr: 0, dw: 0, a: 32'hFFFF_FFFF, gap: 3, x: 8'h5A, exp_addr: 32'hFFFF_FFE0, exp_d: 0, exp_w: 0};
    bus.inst_read = 1'b0; bus.inst_addr = '0;
    bus.data_read = 1'b0; bus.data_write = 1'b0; bus.data_addr = '0;
    bus.data_wdata = {wb[3], wb[2], wb[1], wb[0]};
    bus.pmem_rdata = '0; bus.pmem_resp = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst/strobes", {bus.pmem_read, bus.pmem_write}, 2'b00);
    chk("rst/addr", bus.pmem_address, 32'h0);
    chk("rst/wdata", bus.pmem_wdata, 64'h0);
    chk("rst/resp", {bus.inst_resp, bus.data_resp}, 2'b00);
    chk("rst/inst_rdata", bus.inst_rdata, 256'h0);
    chk("rst/data_rdata", bus.data_rdata, 256'h0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) run(vt[i], $sformatf("vec%0d", i));
    bus.pmem_resp = 1'b1;
    bus.pmem_rdata = '1;
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    chk("idle_resp/strobes", {bus.pmem_read, bus.pmem_write}, 2'b00);
    chk("idle_resp/resp", {bus.inst_resp, bus.data_resp}, 2'b00);
    chk("idle_resp/rdata", bus.inst_rdata, exp_line);
    contend(1'b1, "cont1");
    run('{ir: 0, dr: 1, dw: 0, a: 32'h0000_0300, gap: 0, x: 8'h0F, exp_addr: 32'h0000_0300, exp_d: 1, exp_w: 0}, "dsolo");
`ifdef PMEM_ARB_RR_EN
    contend(1'b0, "cont2");
`else
    contend(1'b1, "cont2");
`endif
    bus.inst_read = 1'b1;
    bus.inst_addr = 32'h0000_0040;
    @(negedge clk);
    bus.inst_read = 1'b0;
    beats(2, 0, 8'hC3, 1'b1, 1'b0, "abort");
    bus.pmem_resp = 1'b1;
    bus.pmem_rdata = rb[2];
    rst_n = 1'b0;
    #1;
    chk("abort/strobes", {bus.pmem_read, bus.pmem_write}, 2'b00);
    chk("abort/addr", bus.pmem_address, 32'h0);
    chk("abort/resp", {bus.inst_resp, bus.data_resp}, 2'b00);
    chk("abort/rdata", bus.inst_rdata, 256'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.pmem_resp = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("abort/no_resp", {bus.inst_resp, bus.data_resp, bus.pmem_read, bus.pmem_write}, 4'b0000);
    end
    exp_line = '0;
    run('{ir: 1, dr: 0, dw: 0, a: 32'h0000_004A, gap: 0, x: 8'h3C, exp_addr: 32'h0000_0040, exp_d: 0, exp_w: 0}, "post_rst");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pmem_arbiter.md
# pmem_arbiter

Shares the single burst physical-memory port of `mp4` between the instruction cache and the data cache. Each cache issues whole-line (256-bit) read or write requests; the arbiter grants one requester at a time and sequences a 4-beat, 64-bit burst on the memory port. On the read path it assembles the four beats into a line and returns it with a one-cycle response. It sits between the two caches and the top-level `pmem_*` ports.

## Interface
- `LINE_W`, 256, cache line width in bits
- `BEAT_W`, 64, memory burst beat width; `LINE_W/BEAT_W` = 4 beats
- `clk`  input  1  system clock
- `rst`  input  1  reset, asynchronous, active-low
- `inst_read`  input  1  icache line read request
- `inst_addr`  input  32  icache line address
- `inst_rdata`  output  256  line returned to icache
- `inst_resp`  output  1  icache request complete, one-cycle pulse
- `data_read`  input  1  dcache line read request
- `data_write`  input  1  dcache line write request
- `data_addr`  input  32  dcache line address
- `data_wdata`  input  256  dcache line to write
- `data_rdata`  output  256  line returned to dcache
- `data_resp`  output  1  dcache request complete, one-cycle pulse
- `pmem_read`  output  1  burst read active
- `pmem_write`  output  1  burst write active
- `pmem_address`  output  32  burst base address, bits [4:0] = 0
- `pmem_wdata`  output  64  current write beat
- `pmem_rdata`  input  64  current read beat
- `pmem_resp`  input  1  beat accepted or valid

## Operation
- FSM states: IDLE, I_RD, D_RD, D_WR, DONE.
- IDLE: if no request is pending, stay in IDLE. Otherwise grant per the priority rule, latch the address with [4:0] forced to 0, latch the dcache write line if needed, clear the beat counter, and move to the granted state.
- Simultaneous `data_read` and `data_write`: treated as a write.
- I_RD / D_RD:
  - `pmem_read` = 1.
  - On each `pmem_resp`, store `pmem_rdata` into line buffer slice [64k+63:64k], where k is the beat counter, then increment k.
  - After the beat with k = 3, go to DONE.
- D_WR:
  - `pmem_write` = 1, `pmem_wdata` = latched line [64k+63:64k].
  - Increment k on each `pmem_resp`; after the beat with k = 3, go to DONE.
- DONE:
  - Assert the granted requester's `*_resp` for exactly one cycle.
  - `*_rdata` = line buffer. It holds its value until the next read burst overwrites it.
  - Next state is IDLE.
- Requesters drop their request in the cycle after seeing resp. Requests are not sampled in DONE.
- Request inputs are ignored outside IDLE. The latched address and data are used for the whole burst.
- `pmem_read`/`pmem_write` stay continuously high across beat gaps (cycles with `pmem_resp` = 0) until the 4th beat is accepted.
- Default priority is fixed: dcache wins over icache.

## Timing
- Reset (asynchronous assert, synchronous release): state = IDLE, k = 0, line buffer = 0. All outputs = 0: `pmem_read`, `pmem_write`, `pmem_address`, `pmem_wdata`, `*_resp`, `*_rdata`.
- Reset asserted mid-burst: abort immediately and drop `pmem_*` strobes in the same cycle. No resp is issued.
- Request seen in IDLE at cycle t → `pmem_read`/`pmem_write` high from t+1 (registered).
- 4th `pmem_resp` at cycle u → `*_resp` high at u+1, IDLE at u+2.
- Earliest back-to-back transaction: strobe reasserted at u+3.
- Minimum transaction with zero-gap beats: request at t, resp at t+5.
- Outputs `pmem_read`, `pmem_write`, `pmem_address`, `*_resp`, `*_rdata` are register-driven. `pmem_wdata` is a mux of the latched line by k.
- A `pmem_resp` arriving in IDLE or DONE is ignored.

## Configuration
- `PMEM_ARB_RR_EN`:
  - Defined: round-robin. A 1-bit `last_grant` register, reset to icache, records the last grantee. When both caches request in IDLE, the non-last grantee wins.
  - Undefined: fixed dcache priority, and `last_grant` is not built.
  - A single requester is granted immediately in both modes.

## Test plan
- icache read of 0x0000_0064, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 with zero gaps → `pmem_address` = 0x0000_0060. `inst_resp` pulses 5 cycles after request. `inst_rdata` = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- dcache write of 0x8000_0020 with line {D3,D2,D1,D0} and 2-cycle gaps between `pmem_resp` → `pmem_wdata` sequence is D0, D1, D2, D3. `pmem_write` stays high throughout. `data_resp` fires 1 cycle after the 4th beat.
- icache and dcache request in the same cycle, macro undefined → dcache is served first. icache is served next with its address unchanged.
- Same stimulus with `PMEM_ARB_RR_EN` defined, repeated twice → first contention grants dcache, second contention grants icache.
- `rst` asserted after 2 beats of a read → all outputs 0 in the same cycle, no resp. After release, a new icache read completes normally with a fresh k = 0.
- `data_read` and `data_write` both high → write burst issued, `pmem_read` never asserted.
